// File: rtl/btb_pkg.sv
// Shared definitions for the parametrised branch target buffer: flush FSM
// state encoding and elaboration-time helpers for index and counter sizing.
package btb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Ceiling log2; ENTRIES is a power of two, so this is the exact index width.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int ctr_weak_taken(input int ctr_w);
        return 1 << (ctr_w - 1);
    endfunction

endpackage

// File: rtl/btb_param_sat_counter.sv
// Next-value logic for the per-entry direction counter: saturating
// increment on taken, saturating decrement on not-taken.
module sat_counter #(
    parameter int W = 2
) (
    input  logic [W-1:0] i_cur,
    input  logic         i_up,
    output logic [W-1:0] o_next
);

    localparam logic [W-1:0] CTR_MAX = '1;
    localparam logic [W-1:0] CTR_MIN = '0;

    always_comb begin
        o_next = i_cur;
        if (i_up) begin
            if (i_cur != CTR_MAX) begin
                o_next = i_cur + W'(1);
            end
        end else begin
            if (i_cur != CTR_MIN) begin
                o_next = i_cur - W'(1);
            end
        end
    end

endmodule

// File: rtl/btb_param.sv
// Direct-mapped BTB with saturating direction counters and a one-entry-per-
// cycle flush FSM. Optional hit/mispredict statistics under `BTB_STATS_EN.
module btb_param
    import btb_pkg::*;
#(
    parameter int ENTRIES  = 16,
    parameter int ADDR_W   = 32,
    parameter int CTR_W    = 2,
    parameter int INIT_CTR = 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [ADDR_W-1:0] LookupPC,
    output logic              PredHit,
    output logic              PredTaken,
    output logic [ADDR_W-1:0] PredTarget,
    input  logic              UpdValid,
    input  logic [ADDR_W-1:0] UpdPC,
    input  logic              UpdTaken,
    input  logic [ADDR_W-1:0] UpdTarget,
    input  logic              FlushReq,
`ifdef BTB_STATS_EN
    input  logic              UpdMispredict,
    output logic [31:0]       HitCount,
    output logic [31:0]       MispredCount,
`endif
    output logic              Busy,
    output state_t            DbgState
);

    localparam int IDX_W = clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(INIT_CTR);
    localparam logic [CTR_W-1:0] CTR_WT   = CTR_W'(ctr_weak_taken(CTR_W));
    localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(ENTRIES - 1);

    // Entry storage
    logic              r_valid  [ENTRIES];
    logic [TAG_W-1:0]  r_tag    [ENTRIES];
    logic [ADDR_W-1:0] r_target [ENTRIES];
    logic [CTR_W-1:0]  r_ctr    [ENTRIES];

    // Flush FSM
    state_t            r_state;
    state_t            w_next_state;
    logic [IDX_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  w_next_cnt;
    logic              r_busy;

    // Lookup path
    logic [IDX_W-1:0]  w_lk_idx;
    logic [TAG_W-1:0]  w_lk_tag;
    logic              w_lk_hit;
    logic              w_lk_taken;

    // Update path
    logic [IDX_W-1:0]  w_up_idx;
    logic [TAG_W-1:0]  w_up_tag;
    logic              w_up_hit;
    logic              w_up_accept;
    logic [CTR_W-1:0]  w_ctr_next;
    logic              w_flush_clear;

    // Instruction PCs are word aligned; the byte-offset bits carry no information.
    logic              w_unused_pc_lsbs;
    assign w_unused_pc_lsbs = ^{LookupPC[1:0], UpdPC[1:0]};

    assign w_lk_idx   = LookupPC[IDX_W+1:2];
    assign w_lk_tag   = LookupPC[ADDR_W-1:IDX_W+2];
    assign w_lk_hit   = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag) && !r_busy;
    assign w_lk_taken = w_lk_hit && r_ctr[w_lk_idx][CTR_W-1];

    assign PredHit    = w_lk_hit;
    assign PredTaken  = w_lk_taken;
    assign PredTarget = w_lk_taken ? r_target[w_lk_idx] : (LookupPC + ADDR_W'(4));

    // UpdValid is a fire-and-forget strobe with no ready: an update is taken
    // only in IDLE without a concurrent FlushReq, otherwise it is lost.
    assign w_up_idx    = UpdPC[IDX_W+1:2];
    assign w_up_tag    = UpdPC[ADDR_W-1:IDX_W+2];
    assign w_up_hit    = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    assign w_up_accept = UpdValid && (r_state == IDLE) && !FlushReq;

    assign w_flush_clear = (r_state == FLUSH);

    sat_counter #(
        .W (CTR_W)
    ) u_sat_counter (
        .i_cur  (r_ctr[w_up_idx]),
        .i_up   (UpdTaken),
        .o_next (w_ctr_next)
    );

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (FlushReq) begin
                    w_next_state = FLUSH;
                    w_next_cnt   = '0;
                end
            end
            FLUSH: begin
                if (FlushReq) begin
                    w_next_cnt = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_next_state = IDLE;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_cnt + IDX_W'(1);
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_busy  <= (w_next_state == FLUSH);
        end
    end

    // Flush clears win over updates; updates are already blocked outside IDLE.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= CTR_INIT;
            end
        end else if (w_flush_clear) begin
            r_valid[r_cnt] <= 1'b0;
            r_ctr[r_cnt]   <= CTR_INIT;
        end else if (w_up_accept) begin
            if (w_up_hit) begin
                r_ctr[w_up_idx] <= w_ctr_next;
                if (UpdTaken) begin
                    r_target[w_up_idx] <= UpdTarget;
                end
            end else if (UpdTaken) begin
                r_valid[w_up_idx]  <= 1'b1;
                r_tag[w_up_idx]    <= w_up_tag;
                r_target[w_up_idx] <= UpdTarget;
                r_ctr[w_up_idx]    <= CTR_WT;
            end
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_mispred_count;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_hit_count     <= '0;
            r_mispred_count <= '0;
        end else begin
            if (w_lk_hit) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_up_accept && UpdMispredict) begin
                r_mispred_count <= r_mispred_count + 32'd1;
            end
        end
    end

    assign HitCount     = r_hit_count;
    assign MispredCount = r_mispred_count;
`endif

    assign Busy     = r_busy;
    assign DbgState = r_state;

endmodule

// File: tb/tb_btb_param.sv
// Self-checking bench for btb_param (ENTRIES=16, CTR_W=2, default build
// without BTB_STATS_EN): directed plan followed by a short random phase.
module tb_btb_param;
    import btb_pkg::*;

    localparam int ENTRIES  = 16;
    localparam int ADDR_W   = 32;
    localparam int CTR_W    = 2;
    localparam int INIT_CTR = 1;

    logic              Clk = 1'b0;
    logic              Rst;
    logic [ADDR_W-1:0] LookupPC;
    logic              PredHit;
    logic              PredTaken;
    logic [ADDR_W-1:0] PredTarget;
    logic              UpdValid;
    logic [ADDR_W-1:0] UpdPC;
    logic              UpdTaken;
    logic [ADDR_W-1:0] UpdTarget;
    logic              FlushReq;
    logic              Busy;
    state_t            DbgState;

    int checks = 0;
    int errors = 0;

    // Expected {hit, taken, target} per lookup
    logic [ADDR_W+1:0] exp_q[$];

    // Reference model of the table
    logic              m_valid [ENTRIES];
    logic [25:0]       m_tag   [ENTRIES];
    logic [ADDR_W-1:0] m_tgt   [ENTRIES];
    logic [CTR_W-1:0]  m_ctr   [ENTRIES];

    btb_param #(
        .ENTRIES  (ENTRIES),
        .ADDR_W   (ADDR_W),
        .CTR_W    (CTR_W),
        .INIT_CTR (INIT_CTR)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .LookupPC   (LookupPC),
        .PredHit    (PredHit),
        .PredTaken  (PredTaken),
        .PredTarget (PredTarget),
        .UpdValid   (UpdValid),
        .UpdPC      (UpdPC),
        .UpdTaken   (UpdTaken),
        .UpdTarget  (UpdTarget),
        .FlushReq   (FlushReq),
        .Busy       (Busy),
        .DbgState   (DbgState)
    );

    // Clock and watchdog
    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
            m_ctr[i]   = CTR_W'(INIT_CTR);
        end
    endtask

    task automatic model_flush();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = CTR_W'(INIT_CTR);
        end
    endtask

    function automatic logic [ADDR_W+1:0] model_predict(input logic [ADDR_W-1:0] pc);
        int   i;
        logic hit;
        logic tk;
        i   = int'(pc[5:2]);
        hit = m_valid[i] && (m_tag[i] == pc[31:6]);
        tk  = hit && m_ctr[i][1];
        return {hit, tk, (tk ? m_tgt[i] : pc + 32'd4)};
    endfunction

    task automatic model_update(input logic [ADDR_W-1:0] pc, input logic tk,
                                input logic [ADDR_W-1:0] tgt);
        int   i;
        logic hit;
        i   = int'(pc[5:2]);
        hit = m_valid[i] && (m_tag[i] == pc[31:6]);
        if (hit) begin
            if (tk) begin
                if (m_ctr[i] != 2'd3) m_ctr[i] = m_ctr[i] + 2'd1;
                m_tgt[i] = tgt;
            end else if (m_ctr[i] != 2'd0) begin
                m_ctr[i] = m_ctr[i] - 2'd1;
            end
        end else if (tk) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = pc[31:6];
            m_tgt[i]   = tgt;
            m_ctr[i]   = 2'd2;
        end
    endtask

    // Driver: lookup pushes the model prediction, then pops it against the DUT
    task automatic lookup(input string tag, input logic [ADDR_W-1:0] pc);
        logic [ADDR_W+1:0] exp;
        logic [ADDR_W+1:0] got;
        LookupPC = pc;
        exp_q.push_back(model_predict(pc));
        #1;
        exp = exp_q.pop_front();
        got = {PredHit, PredTaken, PredTarget};
        check(tag, 64'(got), 64'(exp));
    endtask

    task automatic update(input logic [ADDR_W-1:0] pc, input logic tk,
                          input logic [ADDR_W-1:0] tgt);
        UpdValid  = 1'b1;
        UpdPC     = pc;
        UpdTaken  = tk;
        UpdTarget = tgt;
        tick();
        UpdValid  = 1'b0;
        model_update(pc, tk, tgt);
    endtask

    initial begin
        int                n;
        logic [ADDR_W-1:0] pcs [6];
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] tgt;
        logic              tk;

        pcs = '{32'h00400010, 32'h00400050, 32'h00400090,
                32'h00400014, 32'h00800010, 32'hFFFFFFFC};

        Rst = 1'b0; LookupPC = '0; UpdValid = 1'b0; UpdPC = '0;
        UpdTaken = 1'b0; UpdTarget = '0; FlushReq = 1'b0;
        model_reset();
        repeat (3) @(posedge Clk);
        #1;

        // 1. reset state
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_state", 64'(DbgState), 64'(IDLE));
        lookup("rst_lookup", 32'h00400010);
        check("rst_target", 64'(PredTarget), 64'h00400014);
        @(negedge Clk);
        Rst = 1'b1;
        tick();
        lookup("t1_lookup", 32'h00400010);
        lookup("t1_wrap", 32'hFFFFFFFC);
        check("t1_wrap_target", 64'(PredTarget), 64'h0);

        // 2. allocate on taken
        update(32'h00400010, 1'b1, 32'h00400100);
        lookup("t2_lookup", 32'h00400010);
        check("t2_target", 64'(PredTarget), 64'h00400100);

        // 3. saturation both ways
        update(32'h00400010, 1'b0, 32'h0);
        lookup("t3_nt1", 32'h00400010);
        update(32'h00400010, 1'b0, 32'h0);
        lookup("t3_nt2", 32'h00400010);
        check("t3_nt_target", 64'(PredTarget), 64'h00400014);
        for (int k = 0; k < 5; k++) begin
            update(32'h00400010, 1'b1, 32'h00400100);
            lookup("t3_tk", 32'h00400010);
        end
        update(32'h00400010, 1'b0, 32'h0);
        lookup("t3_sat_nt", 32'h00400010);
        check("t3_sat_taken", 64'(PredTaken), 64'd1);

        // 4. alias, unmapped not-taken, same-cycle lookup/update
        update(32'h00400050, 1'b1, 32'h00400200);
        lookup("t4_alias_old", 32'h00400010);
        check("t4_alias_hit", 64'(PredHit), 64'd0);
        lookup("t4_alias_new", 32'h00400050);
        check("t4_alias_target", 64'(PredTarget), 64'h00400200);
        update(32'h00400094, 1'b0, 32'h00400400);
        lookup("t4_unmapped", 32'h00400094);
        lookup("t4_unchanged", 32'h00400050);
        UpdValid = 1'b1; UpdPC = 32'h00400050; UpdTaken = 1'b1; UpdTarget = 32'h00400300;
        lookup("t4_same_cycle", 32'h00400050);
        tick();
        UpdValid = 1'b0;
        model_update(32'h00400050, 1'b1, 32'h00400300);
        lookup("t4_next_cycle", 32'h00400050);

        // 5. flush with three valid entries; update in flush cycle 5 is dropped
        update(32'h00400020, 1'b1, 32'h00400500);
        update(32'h00400034, 1'b1, 32'h00400600);
        FlushReq = 1'b1;
        tick();
        FlushReq = 1'b0;
        LookupPC = 32'h00400050;
        n = 0;
        while (Busy && n < 100) begin
            check("t5_flush_hit", 64'(PredHit), 64'd0);
            if (n == 5) begin
                UpdValid = 1'b1; UpdPC = 32'h00400080; UpdTaken = 1'b1; UpdTarget = 32'h00400700;
            end
            tick();
            UpdValid = 1'b0;
            n++;
        end
        check("t5_busy_cycles", 64'(n), 64'd16);
        model_flush();
        lookup("t5_after_a", 32'h00400050);
        lookup("t5_after_b", 32'h00400020);
        lookup("t5_after_c", 32'h00400034);
        lookup("t5_dropped", 32'h00400080);

        // 6. reset during flush cycle 7
        update(32'h00400010, 1'b1, 32'h00400100);
        update(32'h00400020, 1'b1, 32'h00400500);
        FlushReq = 1'b1;
        tick();
        FlushReq = 1'b0;
        repeat (6) tick();
        Rst = 1'b0;
        #1;
        model_reset();
        check("t6_busy_async", 64'(Busy), 64'd0);
        check("t6_state", 64'(DbgState), 64'(IDLE));
        lookup("t6_inv_a", 32'h00400010);
        lookup("t6_inv_b", 32'h00400020);
        @(negedge Clk);
        Rst = 1'b1;
        tick();
        update(32'h00400010, 1'b1, 32'h00400100);
        lookup("t6_accept", 32'h00400010);
        check("t6_accept_hit", 64'(PredHit), 64'd1);

        // Random mix of updates and lookups
        for (int k = 0; k < 60; k++) begin
            pc = pcs[$urandom_range(0, 5)];
            if ($urandom_range(0, 1) == 1) begin
                tk  = 1'($urandom_range(0, 1));
                tgt = 32'h00500000 + (32'($urandom_range(0, 255)) << 2);
                update(pc, tk, tgt);
            end
            lookup("rand_lookup", pc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
